// File: rtl/io_tri_bank.sv
// Bidirectional pad bank: registered drive with req/grant turnaround FSM,
// multi-stage input synchroniser and rx_valid flush. IO_GLITCH_FILT_EN adds per-bit glitch filter.
module io_tri_bank #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] chipout,
  input  logic             drv_req,
  input  logic [WIDTH-1:0] drv_data,
  output logic             drv_gnt,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

`ifdef IO_GLITCH_FILT_EN
  localparam int FLUSH = SYNC_STAGES + FILT_CYC;
`else
  localparam int FLUSH = SYNC_STAGES;
`endif
  localparam int CMAX = (TURN_CYC > SYNC_STAGES + FILT_CYC) ? TURN_CYC : SYNC_STAGES + FILT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TURN_LD  = CW'(TURN_CYC);
  localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH);

  localparam logic [1:0] RX      = 2'd0;
  localparam logic [1:0] TURN_TX = 2'd1;
  localparam logic [1:0] TX      = 2'd2;
  localparam logic [1:0] TURN_RX = 2'd3;

  logic [1:0]       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             oe_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  // Counter expiry outranks a drv_req change; drv_req is re-evaluated in the new state.
  always_comb begin
    state_d = state;
    cnt_d   = (cnt != '0) ? cnt - CW'(1) : '0;
    case (state)
      RX: begin
        if (drv_req) begin
          if (TURN_CYC == 0) begin
            state_d = TX;
          end else begin
            state_d = TURN_TX;
            cnt_d   = TURN_LD;
          end
        end
      end
      TURN_TX: begin
        if (cnt <= CW'(1)) begin
          state_d = TX;
        end else if (!drv_req) begin
          state_d = RX;
          cnt_d   = FLUSH_LD;
        end
      end
      TX: begin
        if (!drv_req) begin
          if (TURN_CYC == 0) begin
            state_d = RX;
            cnt_d   = FLUSH_LD;
          end else begin
            state_d = TURN_RX;
            cnt_d   = TURN_LD;
          end
        end
      end
      TURN_RX: begin
        if (cnt <= CW'(1)) begin
          state_d = RX;
          cnt_d   = FLUSH_LD;
        end
      end
      default: begin
        state_d = RX;
        cnt_d   = FLUSH_LD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX;
      cnt   <= FLUSH_LD;
      oe_q  <= 1'b0;
      o_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      oe_q  <= (state_d == TX);
      o_q   <= drv_data;
    end
  end

  assign chipout  = oe_q ? o_q : 'z;
  assign drv_gnt  = oe_q;
  assign rx_valid = (state == RX) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= chipout;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IO_GLITCH_FILT_EN
  localparam int FW = $clog2(FILT_CYC + 1);

  logic [FW-1:0]    fcnt [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // A bit flips only after FILT_CYC consecutive cycles of disagreement with its held value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int unsigned n = 0; n < WIDTH; n++) fcnt[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < WIDTH; n++) begin
        if (sync_out[n] != filt_q[n]) begin
          if (fcnt[n] == FW'(FILT_CYC - 1)) begin
            filt_q[n] <= sync_out[n];
            fcnt[n]   <= '0;
          end else begin
            fcnt[n] <= fcnt[n] + FW'(1);
          end
        end else begin
          fcnt[n] <= '0;
        end
      end
    end
  end

  assign rx_data = filt_q;
`else
  assign rx_data = sync_out;
`endif

endmodule

// File: tb/tb_io_tri_bank.sv
// Directed self-checking bench for io_tri_bank (default parameters, WIDTH=2).
module tb_io_tri_bank;

  localparam int TURN = 2;
`ifdef IO_GLITCH_FILT_EN
  localparam int LAT = 2 + 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_req;
  logic [1:0] drv_data;
  logic       drv_gnt;
  logic [1:0] rx_data;
  logic       rx_valid;
  logic       tb_oe;
  logic [1:0] tb_val;
  wire  [1:0] pad;

  int tests = 0;
  int fails = 0;

  assign pad = tb_oe ? tb_val : 2'bzz;

  io_tri_bank #(
    .WIDTH(2), .SYNC_STAGES(2), .TURN_CYC(TURN), .FILT_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .chipout(pad), .drv_req(drv_req), .drv_data(drv_data),
    .drv_gnt(drv_gnt), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; drv_req = 1'b0; drv_data = 2'b00; tb_oe = 1'b1; tb_val = 2'b11;
    tick(3);
    check("rst_gnt", drv_gnt, 1'b0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_rxdata", rx_data, 2'b00);

    // Reset release with pads held at 11
    rst = 1'b0;
    tick(1);
    check("rel_e1_valid", rx_valid, 1'b0);
    check("rel_e1_gnt", drv_gnt, 1'b0);
    tick(LAT);
    check("rel_rxdata", rx_data, 2'b11);
    check("rel_valid", rx_valid, 1'b1);
    check("rel_gnt", drv_gnt, 1'b0);

    // Request drive: grant TURN+1 edges later
    tb_oe = 1'b0; drv_req = 1'b1; drv_data = 2'b10;
    tick(1);
    check("ttx_e1_gnt", drv_gnt, 1'b0);
    check("ttx_e1_valid", rx_valid, 1'b0);
    tick(1);
    check("ttx_e2_gnt", drv_gnt, 1'b0);
    tick(1);
    check("tx_gnt", drv_gnt, 1'b1);
    check("tx_pad10", pad, 2'b10);
    check("tx_valid", rx_valid, 1'b0);
    drv_data = 2'b01;
    tick(1);
    check("tx_pad01", pad, 2'b01);
    check("tx_gnt_hold", drv_gnt, 1'b1);

    // Release: grant drops after 1 edge, rx_valid after TURN+LAT+1 edges
    drv_req = 1'b0;
    tick(1);
    check("trx_gnt", drv_gnt, 1'b0);
    check("trx_e1_valid", rx_valid, 1'b0);
    tb_oe = 1'b1; tb_val = 2'b00;
    for (int i = 2; i <= TURN + LAT; i++) begin
      tick(1);
      check("trx_flush_valid", rx_valid, 1'b0);
    end
    tick(1);
    check("trx_valid_rise", rx_valid, 1'b1);
    check("trx_rxdata", rx_data, 2'b00);

    // One-cycle request pulse aborts in TURN_TX
    tb_val = 2'b01; drv_req = 1'b1;
    tick(1);
    drv_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("pulse_gnt", drv_gnt, 1'b0);
    end
    check("pulse_valid", rx_valid, 1'b1);
    check("pulse_rxdata", rx_data, 2'b01);

    // drv_req drops exactly as the turn counter expires: TX is still entered
    tb_oe = 1'b0; drv_req = 1'b1; drv_data = 2'b11;
    tick(2);
    drv_req = 1'b0;
    tick(1);
    check("expiry_gnt", drv_gnt, 1'b1);
    check("expiry_pad", pad, 2'b11);
    tick(1);
    check("expiry_drop", drv_gnt, 1'b0);
    tb_oe = 1'b1; tb_val = 2'b10;
    tick(TURN + LAT + 1);
    check("expiry_back_valid", rx_valid, 1'b1);
    check("expiry_rxdata", rx_data, 2'b10);

    // Asynchronous reset while driving
    tb_oe = 1'b0; drv_req = 1'b1; drv_data = 2'b01;
    tick(TURN + 2);
    check("pre_rst_gnt", drv_gnt, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", drv_gnt, 1'b0);
    check("async_rst_rxdata", rx_data, 2'b00);
    drv_req = 1'b0; tb_oe = 1'b1; tb_val = 2'b10;
    tick(1);
    rst = 1'b0;
    tick(LAT + 1);
    check("post_rst_valid", rx_valid, 1'b1);
    check("post_rst_gnt", drv_gnt, 1'b0);
    check("post_rst_rxdata", rx_data, 2'b10);

`ifdef IO_GLITCH_FILT_EN
    // 2-cycle glitch is rejected
    tb_val = 2'b11;
    tick(2);
    tb_val = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_rxdata", rx_data, 2'b10);
    end
    // 4-cycle pulse appears 5 cycles after onset
    tb_val = 2'b11;
    tick(4);
    check("pulse4_e4", rx_data, 2'b10);
    tb_val = 2'b10;
    tick(1);
    check("pulse4_e5", rx_data, 2'b11);
`else
    // Pad to rx_data latency of SYNC_STAGES cycles
    tb_val = 2'b01;
    tick(1);
    check("lat_e1", rx_data, 2'b10);
    tick(1);
    check("lat_e2", rx_data, 2'b01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_tri_bank.md
# io_tri_bank

Parametrised bank of WIDTH bidirectional pad channels sharing one direction control, used for the USB D+/D- pair and other half-duplex pins. It adds what a plain tristate pad buffer lacks: registered output data and output enable, a request/grant handshake for direction changes, and enforced bus-turnaround dead cycles. It also provides a multi-stage input synchroniser with a receive-valid qualifier. It sits between the pad ring and the link-layer logic.

## Interface
- WIDTH, 2: number of pad channels.
- SYNC_STAGES, 2: input synchroniser depth, legal 2..4.
- TURN_CYC, 2: dead cycles with OE low on every direction change, legal 0..15.
- FILT_CYC, 3: glitch-filter stability count, legal 1..15; used only with the filter compiled in.
- clk  in  1  bank clock.
- rst  in  1  reset, asynchronous, active-high.
- chipout  inout  WIDTH  pad nets.
- drv_req  in  1  level request to drive the pads.
- drv_data  in  WIDTH  value to drive; sampled every cycle.
- drv_gnt  out  1  high exactly while pad drivers are enabled.
- rx_data  out  WIDTH  synchronised (optionally filtered) pad value.
- rx_valid  out  1  rx_data is trustworthy: bank is receiving and the pipeline is flushed.

## Operation
- FSM states: RX, TURN_TX, TX, TURN_RX. Reset state is RX.
- RX with drv_req=1 goes to TURN_TX, with turn counter = TURN_CYC. If TURN_CYC=0, it goes directly to TX.
- In TURN_TX the counter decrements each cycle. When the counter reaches 0 the FSM goes to TX. If drv_req drops first, the FSM returns to RX; no drive ever occurs.
- TX with drv_req=0 goes to TURN_RX, with counter = TURN_CYC. If TURN_CYC=0, it goes directly to RX.
- TURN_RX always completes and ignores drv_req, then goes to RX. A held drv_req then re-enters TURN_TX on the next cycle.
- oe_q is registered and equals (next state == TX); drv_gnt = oe_q.
- o_q <= drv_data every cycle. Each channel drives chipout[n] = o_q[n] when oe_q, else Z.
- Input path: per-bit SYNC_STAGES flop chain on chipout. rx_data = last stage, or the filter output when the filter is compiled in.
- rx_valid: a flush counter loads SYNC_STAGES (+FILT_CYC when filtered) on entry to RX, including out of reset.
  - The counter decrements in RX.
  - rx_valid = (state==RX) and (counter==0).
  - rx_valid is 0 in all other states.
- Counter width is $clog2(max(TURN_CYC, SYNC_STAGES+FILT_CYC)+1); arithmetic is unsigned and saturates at 0.

## Timing
- Reset values: drv_gnt=0, rx_valid=0, rx_data=0, o_q=0, all sync/filter flops 0; chipout is Z.
- Asserting rst mid-TX tristates the pads immediately, without waiting for a clock edge.
- drv_req rising in RX: drv_gnt rises TURN_CYC+1 edges later, and the pads drive that same cycle.
- drv_data to pad latency: 1 cycle while granted.
- drv_req falling in TX: drv_gnt falls 1 edge later, and the pads release that same cycle.
- After release, rx_valid rises TURN_CYC+SYNC_STAGES(+FILT_CYC)+1 edges after drv_req falls.
- Pad to rx_data latency: SYNC_STAGES cycles unfiltered, SYNC_STAGES+FILT_CYC filtered.
- Simultaneous counter expiry and drv_req change: the expiry transition is taken first, and drv_req is evaluated in the new state next cycle.

## Configuration
- IO_GLITCH_FILT_EN defined: each bit has a FILT_CYC-deep stability counter.
  - rx_data[n] updates only after the synchroniser output differs from rx_data[n] for FILT_CYC consecutive cycles.
  - The counter clears on any cycle where the two are equal.
  - The rx_valid flush includes FILT_CYC.
- IO_GLITCH_FILT_EN undefined: no filter logic; rx_data is the synchroniser output, and FILT_CYC is ignored.

## Test plan
- Reset with pads pulled to 2'b11, then release: rx_data=2'b11 and rx_valid=1 at edge 3 (unfiltered, SYNC_STAGES=2); drv_gnt=0 and pads Z throughout.
- TURN_CYC=2, drv_req=1 with drv_data=2'b10: drv_gnt=1 at edge 3 with pads = 10. Change drv_data to 01: pads = 01 one cycle later.
- Drop drv_req in TX: pads Z after 1 edge, rx_valid=0 during the 2 turn cycles, rx_valid=1 two cycles after TURN_RX exits.
- Pulse drv_req for 1 cycle in RX (TURN_CYC=2): FSM returns to RX from TURN_TX; drv_gnt never asserts and pads never drive.
- Assert rst while in TX: pads Z and drv_gnt=0 before the next clk edge; FSM in RX after reset releases.
- With IO_GLITCH_FILT_EN and FILT_CYC=3:
  - a 2-cycle pad pulse leaves rx_data unchanged;
  - a 4-cycle pulse updates rx_data 5 cycles after pad onset.
